// File: rtl/tdm_mux4_if.sv
// tdm_mux4_if -- bundle of the 4:1 TDM multiplexer's handshake and data signals.
//
// Handshake: a beat moves across a port on a rising clk edge where that
// port's valid and ready are both high. Valid never waits on ready.
//
// Signals:
//   in_data   [4*WIDTH-1:0]  channel payloads, channel i at [i*WIDTH +: WIDTH]
//   in_valid  [3:0]          per-channel beat available
//   in_ready  [3:0]          per-channel beat accepted this cycle
//   out_data  [WIDTH-1:0]    registered payload
//   out_sel   [1:0]          registered source channel index
//   out_valid                output register holds a beat
//   out_ready                downstream accepts the beat
//
// Modports: slave = the multiplexer, master = the environment driving it.
interface tdm_mux4_if #(
  parameter int WIDTH = 8
);
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/tdm_mux4.sv
// tdm_mux4 -- four-channel time-division multiplexer into one registered
// output stage carrying the payload plus its source index (out_sel) for a
// downstream 1:4 demux.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  tdm_mux4_if.slave (in_data/in_valid/in_ready, out_data/out_sel/
//        out_valid/out_ready)
//
// Default scheduling is work-conserving round-robin: priority starts at the
// channel after the last winner. Defining TDM_FIXED_SLOT_EN switches to strict
// time-division slots: a free-running slot counter (advancing whenever the
// output register can load) grants only its own channel, and idle slots
// produce a bubble.
module tdm_mux4 #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  tdm_mux4_if.slave   bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_sel_q;
  logic             load;
  logic             found;
  logic [1:0]       win;
  logic [3:0]       in_ready_c;
  logic [WIDTH-1:0] ch_data [4];

`ifdef TDM_FIXED_SLOT_EN
  logic [1:0] slot;
`else
  logic [1:0] last;
  logic [1:0] cand;
`endif

  // Output register can take a new beat when empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef TDM_FIXED_SLOT_EN
  always_comb begin
    win   = slot;
    found = bus.in_valid[slot];
  end
`else
  // Scan last+1 .. last+4 (mod 4); the first valid channel wins, so the
  // previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = '0;
    for (int k = 1; k < 5; k++) begin
      cand = last + k[1:0];
      if (!found && bus.in_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
`endif

  // Grant depends only on valids, output state and pointer, never on data.
  always_comb begin
    in_ready_c = 4'b0000;
    if (!rst && load && found) begin
      in_ready_c = 4'b0001 << win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
`ifdef TDM_FIXED_SLOT_EN
      slot        <= 2'd0;
`else
      last        <= 2'b11;
`endif
    end else if (load) begin
`ifdef TDM_FIXED_SLOT_EN
      slot <= slot + 2'd1;
`endif
      if (found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ch_data[win];
        out_sel_q   <= win;
`ifndef TDM_FIXED_SLOT_EN
        last        <= win;
`endif
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_tdm_mux4.sv
// tb_tdm_mux4 -- directed self-checking bench for tdm_mux4 with a reference
// model and an expected-beat queue. Build with TDM_FIXED_SLOT_EN to exercise
// the fixed-slot mode.
module tb_tdm_mux4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tdm_mux4_if #(.WIDTH(WIDTH)) bus ();

  tdm_mux4 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_sel;
  logic [1:0]       m_last;
  logic [1:0]       m_slot;
  logic [9:0]       exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] chan(input logic [1:0] i);
    logic [4*WIDTH-1:0] d;
    d = bus.in_data;
    return d[i*WIDTH +: WIDTH];
  endfunction

  // One clock cycle: drive inputs, check grant and any consumed beat before
  // the edge, update the model at the edge, check the output register after.
  task automatic step(input logic [3:0] v, input logic ordy, input logic r);
    logic       m_load;
    logic       found;
    logic [1:0] win;
    logic [3:0] exp_rdy;
    logic [9:0] beat;
    logic [1:0] idx;
    rst           = r;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    #1;
    m_load = !m_valid || ordy;
    found  = 1'b0;
    win    = 2'd0;
`ifdef TDM_FIXED_SLOT_EN
    win   = m_slot;
    found = v[m_slot];
`else
    for (int k = 1; k < 5; k++) begin
      idx = 2'(m_last + 2'(k));
      if (!found && v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`endif
    exp_rdy = (!r && m_load && found) ? (4'b0001 << win) : 4'b0000;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (!r && ordy && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(bus.out_valid), 32'd0);
      end else begin
        beat = exp_q.pop_front();
        chk("sb_sel", 32'(bus.out_sel), 32'(beat[9:8]));
        chk("sb_data", 32'(bus.out_data), 32'(beat[7:0]));
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 2'd0;
      m_last  = 2'b11;
      m_slot  = 2'd0;
      exp_q.delete();
    end else if (m_load) begin
      m_slot = m_slot + 2'd1;
      if (found) begin
        m_valid = 1'b1;
        m_data  = chan(win);
        m_sel   = win;
        m_last  = win;
        exp_q.push_back({win, chan(win)});
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_sel", 32'(bus.out_sel), 32'(m_sel));
      chk("out_data", 32'(bus.out_data), 32'(m_data));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int vcount;
    checks        = 0;
    errors        = 0;
    m_valid       = 1'b0;
    m_data        = '0;
    m_sel         = 2'd0;
    m_last        = 2'b11;
    m_slot        = 2'd0;
    rst           = 1'b1;
    bus.in_valid  = 4'h0;
    bus.out_ready = 1'b0;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset with every channel requesting.
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'd0);

    // Rotation 0,1,2,3,0 back to back.
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 1'b1, 1'b0);
      chk("rot_sel", 32'(bus.out_sel), 32'(k % 4));
      chk("rot_data", 32'(bus.out_data), 32'(8'hA0 + (k % 4)));
    end

    // Backpressure: held beat from channel 0 must not move.
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 1'b0, 1'b0);
      chk("bp_sel", 32'(bus.out_sel), 32'd0);
      chk("bp_data", 32'(bus.out_data), 32'h A0);
    end
    step(4'hF, 1'b1, 1'b0);
    chk("bp_release_sel", 32'(bus.out_sel), 32'd1);
    chk("bp_release_data", 32'(bus.out_data), 32'hA1);

`ifndef TDM_FIXED_SLOT_EN
    // Sparse: only channel 2, then all valid -> channel 3 is next after 2.
    bus.in_data[23:16] = 8'h5C;
    for (int k = 0; k < 4; k++) begin
      step(4'b0100, 1'b1, 1'b0);
      chk("sparse_valid", 32'(bus.out_valid), 32'd1);
      chk("sparse_sel", 32'(bus.out_sel), 32'd2);
      chk("sparse_data", 32'(bus.out_data), 32'h5C);
    end
    step(4'hF, 1'b1, 1'b0);
    chk("sparse_last_sel", 32'(bus.out_sel), 32'd3);
`else
    // Fixed slots: channel 1 alone is served once per four cycles.
    step(4'h0, 1'b1, 1'b1);
    vcount = 0;
    for (int k = 0; k < 8; k++) begin
      step(4'b0010, 1'b1, 1'b0);
      if (bus.out_valid === 1'b1) begin
        vcount++;
        chk("slot_sel", 32'(bus.out_sel), 32'd1);
      end
    end
    chk("slot_count", 32'(vcount), 32'd2);
`endif

    // Idle inputs drain the output.
    step(4'h0, 1'b1, 1'b0);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);

    // Reset while a beat is held drops it.
    step(4'hF, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    step(4'hF, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    step(4'hF, 1'b1, 1'b0);
    chk("post_rst_sel", 32'(bus.out_sel), 32'd0);
    step(4'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
